// File: rtl/battle_pkg.sv
// Shared battle constants: USB keycodes, turn FSM state encoding, default text timeout.
package battle_pkg;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;

   // One second of text auto-advance at 50 MHz
   localparam int TIMEOUT_CYC_DEF = 50_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ORDER,
      ST_ATK1,
      ST_TEXT1,
      ST_ATK2,
      ST_TEXT2,
      ST_RESOLVE,
      ST_END
   } turn_state_t;

endpackage

// File: rtl/key_press_edge.sv
// Single-cycle pulse on the first cycle a given keycode appears; holding the key gives one pulse.
// Combinational from keycode against a registered history bit; no backpressure.
module key_press_edge #(
   parameter logic [7:0] KEY = 8'h28
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       press
);

   logic hit;
   logic hit_q;

   assign hit   = (keycode == KEY);
   assign press = hit & ~hit_q;

   always_ff @(posedge Clk) begin
      if (Reset) hit_q <= 1'b0;
      else       hit_q <= hit;
   end

endmodule

// File: rtl/turn_scheduler.sv
// Orders one battle turn by speed, shares the damage unit via calc_req/calc_done, gates text on ENTER.
// start_turn -> calc_req in 2 cycles; outputs registered; TURN_SCHED_TIMEOUT_EN adds text auto-advance.
module turn_scheduler
   import battle_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start_turn,
   input  logic [7:0] player_spd,
   input  logic [7:0] enemy_spd,
   input  logic       tie_bit,
   input  logic [7:0] player_hp,
   input  logic [7:0] enemy_hp,
   input  logic       player_last,
   input  logic       enemy_last,
   input  logic [7:0] keycode,
   output logic       calc_req,
   output logic       calc_is_player,
   input  logic       calc_done,
   output logic       show_player_text,
   output logic       show_enemy_text,
   output logic       switch_player,
   output logic       switch_enemy,
   output logic       win,
   output logic       lose,
   output logic       turn_done,
   output logic       busy
);

   turn_state_t state;
   logic        player_first;
   logic        key_ack;
   logic        ack;
   logic        player_wins_order;
   logic        defender_down;
   logic        enemy_out;
   logic        player_out;
   logic        win_now;
   logic        lose_now;

   key_press_edge #(.KEY(KEY_ENTER)) u_enter (
      .Clk     (Clk),
      .Reset   (Reset),
      .keycode (keycode),
      .press   (key_ack)
   );

`ifdef TURN_SCHED_TIMEOUT_EN
   localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYC - 1);

   logic [25:0] to_cnt;
   logic        in_text;
   logic        timeout_hit;

   assign in_text     = (state == ST_TEXT1) || (state == ST_TEXT2);
   assign timeout_hit = in_text && (to_cnt == TO_LAST);
   assign ack         = key_ack | timeout_hit;

   // Held at zero outside TEXT so every entry starts a fresh period
   always_ff @(posedge Clk) begin
      if (Reset)                 to_cnt <= '0;
      else if (!in_text || ack)  to_cnt <= '0;
      else                       to_cnt <= to_cnt + 26'd1;
   end
`else
   assign ack = key_ack;
`endif

   assign player_wins_order = (player_spd > enemy_spd) ||
                              ((player_spd == enemy_spd) && tie_bit);

   // After the first attack the defender is whoever did not strike first
   assign defender_down = player_first ? (enemy_hp == 8'd0) : (player_hp == 8'd0);

   assign enemy_out  = (enemy_hp == 8'd0);
   assign player_out = (player_hp == 8'd0);
   assign win_now    = enemy_out && enemy_last;
   assign lose_now   = player_out && player_last && !win_now;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state            <= ST_IDLE;
         player_first     <= 1'b0;
         calc_req         <= 1'b0;
         calc_is_player   <= 1'b0;
         show_player_text <= 1'b0;
         show_enemy_text  <= 1'b0;
         switch_player    <= 1'b0;
         switch_enemy     <= 1'b0;
         win              <= 1'b0;
         lose             <= 1'b0;
         turn_done        <= 1'b0;
         busy             <= 1'b0;
      end else begin
         switch_player <= 1'b0;
         switch_enemy  <= 1'b0;
         win           <= 1'b0;
         lose          <= 1'b0;
         turn_done     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_turn) begin
                  player_first <= player_wins_order;
                  busy         <= 1'b1;
                  state        <= ST_ORDER;
               end
            end

            ST_ORDER: begin
               calc_req       <= 1'b1;
               calc_is_player <= player_first;
               state          <= ST_ATK1;
            end

            ST_ATK1: begin
               if (calc_done) begin
                  calc_req         <= 1'b0;
                  show_player_text <= player_first;
                  show_enemy_text  <= ~player_first;
                  state            <= ST_TEXT1;
               end
            end

            ST_TEXT1: begin
               if (ack) begin
                  show_player_text <= 1'b0;
                  show_enemy_text  <= 1'b0;
                  if (defender_down) begin
                     state <= ST_RESOLVE;
                  end else begin
                     calc_req       <= 1'b1;
                     calc_is_player <= ~player_first;
                     state          <= ST_ATK2;
                  end
               end
            end

            ST_ATK2: begin
               if (calc_done) begin
                  calc_req         <= 1'b0;
                  show_player_text <= ~player_first;
                  show_enemy_text  <= player_first;
                  state            <= ST_TEXT2;
               end
            end

            ST_TEXT2: begin
               if (ack) begin
                  show_player_text <= 1'b0;
                  show_enemy_text  <= 1'b0;
                  state            <= ST_RESOLVE;
               end
            end

            // Pulses are registered here so they appear during END
            ST_RESOLVE: begin
               win   <= win_now;
               lose  <= lose_now;
               if (!win_now && !lose_now) begin
                  switch_enemy  <= enemy_out;
                  switch_player <= player_out;
                  turn_done     <= 1'b1;
               end
               state <= ST_END;
            end

            ST_END: begin
               calc_is_player <= 1'b0;
               busy           <= 1'b0;
               state          <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed, table-driven bench for turn_scheduler plus hand-written corner sequences.
module tb_turn_scheduler;
   import battle_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       start_turn;
   logic [7:0] player_spd, enemy_spd;
   logic       tie_bit;
   logic [7:0] player_hp, enemy_hp;
   logic       player_last, enemy_last;
   logic [7:0] keycode;
   logic       calc_req, calc_is_player, calc_done;
   logic       show_player_text, show_enemy_text;
   logic       switch_player, switch_enemy, win, lose, turn_done, busy;

   int total = 0;
   int bad   = 0;

`ifdef TURN_SCHED_TIMEOUT_EN
   localparam int HOLD = 7;
`else
   localparam int HOLD = 98;
`endif

   always #5 Clk = ~Clk;

   turn_scheduler #(.TIMEOUT_CYC(10)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .start_turn       (start_turn),
      .player_spd       (player_spd),
      .enemy_spd        (enemy_spd),
      .tie_bit          (tie_bit),
      .player_hp        (player_hp),
      .enemy_hp         (enemy_hp),
      .player_last      (player_last),
      .enemy_last       (enemy_last),
      .keycode          (keycode),
      .calc_req         (calc_req),
      .calc_is_player   (calc_is_player),
      .calc_done        (calc_done),
      .show_player_text (show_player_text),
      .show_enemy_text  (show_enemy_text),
      .switch_player    (switch_player),
      .switch_enemy     (switch_enemy),
      .win              (win),
      .lose             (lose),
      .turn_done        (turn_done),
      .busy             (busy)
   );

   typedef struct {
      logic [7:0] pspd, espd;
      logic       tie;
      logic [7:0] p_hp1, e_hp1, p_hp2, e_hp2;
      logic       plast, elast;
      logic       exp_pf, exp_atk2, exp_swp, exp_swe, exp_win, exp_lose, exp_done;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [10:0] all_outs();
      return {calc_req, calc_is_player, show_player_text, show_enemy_text, switch_player,
              switch_enemy, win, lose, turn_done, busy, 1'b0};
   endfunction

   function automatic logic [4:0] pulses();
      return {switch_player, switch_enemy, win, lose, turn_done};
   endfunction

   task automatic begin_turn(input logic [7:0] ps, input logic [7:0] es, input logic tb_tie);
      player_spd = ps;  enemy_spd = es;  tie_bit = tb_tie;
      player_hp  = 8'd30; enemy_hp = 8'd30;
      start_turn = 1'b1;
      tick();
      start_turn = 1'b0;
      tick();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      player_last = v.plast;  enemy_last = v.elast;
      begin_turn(v.pspd, v.espd, v.tie);
      chk($sformatf("v%0d calc_req t+2", idx), calc_req, 1'b1);
      chk($sformatf("v%0d first attacker", idx), calc_is_player, v.exp_pf);
      tick();
      chk($sformatf("v%0d calc_req held", idx), calc_req, 1'b1);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      chk($sformatf("v%0d text1", idx), {show_player_text, show_enemy_text, calc_req},
          {v.exp_pf, ~v.exp_pf, 1'b0});
      player_hp = v.p_hp1;  enemy_hp = v.e_hp1;
      tick();
      keycode = KEY_ENTER;
      tick();
      keycode = 8'h00;
      if (v.exp_atk2) begin
         chk($sformatf("v%0d atk2 req", idx), {calc_req, calc_is_player}, {1'b1, ~v.exp_pf});
         calc_done = 1'b1;
         tick();
         calc_done = 1'b0;
         chk($sformatf("v%0d text2", idx), {show_player_text, show_enemy_text},
             {~v.exp_pf, v.exp_pf});
         player_hp = v.p_hp2;  enemy_hp = v.e_hp2;
         keycode = KEY_ENTER;
         tick();
         keycode = 8'h00;
      end else begin
         chk($sformatf("v%0d skip atk2", idx), {calc_req, show_player_text, show_enemy_text}, 3'b000);
         player_hp = v.p_hp2;  enemy_hp = v.e_hp2;
      end
      chk($sformatf("v%0d resolve quiet", idx), {pulses(), busy}, 6'b000001);
      tick();
      chk($sformatf("v%0d end pulses", idx), pulses(),
          {v.exp_swp, v.exp_swe, v.exp_win, v.exp_lose, v.exp_done});
      tick();
      chk($sformatf("v%0d back idle", idx), {pulses(), busy}, 6'b000000);
   endtask

   initial begin
      //          pspd   espd   tie  p_hp1  e_hp1  p_hp2  e_hp2  pl ell  pf at2 swp swe win los don
      vecs[0] = '{8'd50, 8'd30, 1'b0, 8'd20, 8'd10, 8'd20, 8'd10, 0, 0,   1, 1,  0,  0,  0,  0,  1};
      vecs[1] = '{8'd40, 8'd40, 1'b0, 8'd20, 8'd10, 8'd20, 8'd10, 0, 0,   0, 1,  0,  0,  0,  0,  1};
      vecs[2] = '{8'd40, 8'd40, 1'b1, 8'd20, 8'd10, 8'd20, 8'd10, 0, 0,   1, 1,  0,  0,  0,  0,  1};
      vecs[3] = '{8'd60, 8'd10, 1'b0, 8'd20, 8'd0,  8'd20, 8'd0,  0, 0,   1, 0,  0,  1,  0,  0,  1};
      vecs[4] = '{8'd10, 8'd60, 1'b0, 8'd5,  8'd30, 8'd0,  8'd30, 1, 0,   0, 1,  0,  0,  0,  1,  0};
      vecs[5] = '{8'd30, 8'd20, 1'b0, 8'd25, 8'd5,  8'd0,  8'd0,  1, 1,   1, 1,  0,  0,  1,  0,  0};
      vecs[6] = '{8'd255,8'd0,  1'b0, 8'd9,  8'd4,  8'd0,  8'd0,  0, 0,   1, 1,  1,  1,  0,  0,  1};

      Reset = 1'b1;  start_turn = 1'b0;  player_spd = 8'd0;  enemy_spd = 8'd0;  tie_bit = 1'b0;
      player_hp = 8'd30;  enemy_hp = 8'd30;  player_last = 1'b0;  enemy_last = 1'b0;
      keycode = 8'h00;  calc_done = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      chk("reset outputs", all_outs(), 11'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Enemy KOs the player in its first strike: 0 vs 255 puts the enemy first
      player_last = 1'b0;  enemy_last = 1'b0;
      begin_turn(8'd0, 8'd255, 1'b1);
      chk("unsigned order", calc_is_player, 1'b0);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      player_hp = 8'd0;
      keycode = KEY_ENTER;
      tick();
      keycode = 8'h00;
      chk("player ko no atk2", calc_req, 1'b0);
      tick();
      chk("switch_player only", pulses(), 5'b10001);
      tick();

      // ENTER held across TEXT1, ATK2 and TEXT2 gives a single advance
      begin_turn(8'd50, 8'd30, 1'b0);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      keycode = KEY_ENTER;
      tick();
      chk("held enter advance", {calc_req, calc_is_player}, 2'b10);
      start_turn = 1'b1;
      tick();
      start_turn = 1'b0;
      chk("start ignored", {calc_req, calc_is_player, busy}, 3'b101);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      for (int k = 0; k < HOLD; k++) tick();
      chk("text2 waits", {show_enemy_text, show_player_text}, 2'b10);
      keycode = 8'h00;
      tick();
      keycode = KEY_ENTER;
      tick();
      keycode = 8'h00;
      chk("new press advances", {show_enemy_text, busy}, 2'b01);
      tick();
      chk("held turn done", pulses(), 5'b00001);
      tick();
      chk("held idle", busy, 1'b0);

      // Reset while ATK2 has calc_req high
      begin_turn(8'd50, 8'd30, 1'b0);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      keycode = KEY_ENTER;
      tick();
      keycode = 8'h00;
      chk("atk2 req before reset", calc_req, 1'b1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("reset mid-turn", all_outs(), 11'd0);
      tick();
      chk("no pulses after reset", {pulses(), busy}, 6'b000000);

`ifdef TURN_SCHED_TIMEOUT_EN
      begin_turn(8'd50, 8'd30, 1'b0);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      chk("timeout not yet", {show_player_text, calc_req}, 2'b10);
      tick();
      chk("timeout advance", {show_player_text, calc_req}, 2'b01);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
